// File: rtl/total_cpu_pkg.sv
// total_cpu_pkg: opcodes, ALU operations, memory sizes and default program for total_cpu
package total_cpu_pkg;
  localparam int IMEM_WORDS = 64;
  localparam int DMEM_WORDS = 32;
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_XORI = 6'h0e;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  typedef enum logic [3:0] {
    ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_LUI, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_e;
  // word i lives at bits [i*32 +: 32]
  localparam logic [IMEM_WORDS*32-1:0] ROM_IMAGE = {
    {((IMEM_WORDS-8)*32){1'b0}},
    32'h08000000, 32'h20070001, 32'h10A60001, 32'h8C860000,
    32'hAC850000, 32'h20050004, 32'h34240050, 32'h3C010000
  };
endpackage

// File: rtl/total_cpu_alu.sv
// total_cpu_alu: combinational ALU; zero flags a null result for branch compare
module total_cpu_alu
  import total_cpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  input  alu_op_e     alu_op,
  output logic [31:0] result,
  output logic        zero
);
  always_comb begin
    case (alu_op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_LUI: result = {b[15:0], 16'h0};
      ALU_SLL: result = b << shamt;
      ALU_SRL: result = b >> shamt;
      ALU_SRA: result = $signed(b) >>> shamt;
      default: result = '0;
    endcase
  end
  assign zero = result == '0;
endmodule

// File: rtl/total_cpu.sv
// total_cpu: single-cycle MIPS-subset CPU with ROM, regfile and data RAM
// Define TOTAL_CPU_SHIFT_EN to implement sll/srl/sra; otherwise they execute as NOPs.
module total_cpu #(
  parameter int IMEM_WORDS = total_cpu_pkg::IMEM_WORDS,
  parameter int DMEM_WORDS = total_cpu_pkg::DMEM_WORDS,
  parameter logic [IMEM_WORDS*32-1:0] ROM = total_cpu_pkg::ROM_IMAGE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_clk,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] aluout,
  output logic [31:0] memout
);
  import total_cpu_pkg::*;
  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);
  logic [31:0] rf [32];
  logic [31:0] ram [DMEM_WORDS];
  logic [31:0] rs_val, rt_val, imm, pc4, result, wdata, pc_next;
  logic [5:0] op, fn;
  logic [4:0] dst;
  alu_op_e alu_op;
  logic use_imm, zext, wreg, load, store, jump, jr, jal, beq, bne, zero, taken;
  assign inst = ROM[pc[IW+1:2]*32 +: 32];
  assign op = inst[31:26];
  assign fn = inst[5:0];
  assign rs_val = rf[inst[25:21]];
  assign rt_val = rf[inst[20:16]];
  assign imm = zext ? {16'h0, inst[15:0]} : {{16{inst[15]}}, inst[15:0]};
  assign pc4 = pc + 32'd4;
  always_comb begin
    alu_op = ALU_NONE;
    use_imm = 1'b1;
    zext = 1'b0;
    wreg = 1'b0;
    load = 1'b0;
    store = 1'b0;
    jump = 1'b0;
    jr = 1'b0;
    jal = 1'b0;
    beq = 1'b0;
    bne = 1'b0;
    case (op)
      OP_R: begin
        use_imm = 1'b0;
        case (fn)
          FN_ADD: alu_op = ALU_ADD;
          FN_SUB: alu_op = ALU_SUB;
          FN_AND: alu_op = ALU_AND;
          FN_OR:  alu_op = ALU_OR;
          FN_XOR: alu_op = ALU_XOR;
`ifdef TOTAL_CPU_SHIFT_EN
          FN_SLL: alu_op = ALU_SLL;
          FN_SRL: alu_op = ALU_SRL;
          FN_SRA: alu_op = ALU_SRA;
`endif
          FN_JR:  jr = 1'b1;
          default: ;
        endcase
        wreg = alu_op != ALU_NONE;
      end
      OP_J:    jump = 1'b1;
      OP_JAL:  begin jump = 1'b1; jal = 1'b1; wreg = 1'b1; end
      OP_BEQ:  begin alu_op = ALU_SUB; use_imm = 1'b0; beq = 1'b1; end
      OP_BNE:  begin alu_op = ALU_SUB; use_imm = 1'b0; bne = 1'b1; end
      OP_ADDI: begin alu_op = ALU_ADD; wreg = 1'b1; end
      OP_ANDI: begin alu_op = ALU_AND; zext = 1'b1; wreg = 1'b1; end
      OP_ORI:  begin alu_op = ALU_OR; zext = 1'b1; wreg = 1'b1; end
      OP_XORI: begin alu_op = ALU_XOR; zext = 1'b1; wreg = 1'b1; end
      OP_LUI:  begin alu_op = ALU_LUI; wreg = 1'b1; end
      OP_LW:   begin alu_op = ALU_ADD; wreg = 1'b1; load = 1'b1; end
      OP_SW:   begin alu_op = ALU_ADD; store = 1'b1; end
      default: ;
    endcase
  end
  total_cpu_alu u_alu (
    .a(rs_val),
    .b(use_imm ? imm : rt_val),
    .shamt(inst[10:6]),
    .alu_op(alu_op),
    .result(result),
    .zero(zero)
  );
  assign dst = jal ? 5'd31 : op == OP_R ? inst[15:11] : inst[20:16];
  assign aluout = jal ? pc4 : result;
  assign memout = ram[aluout[DW+1:2]];
  assign wdata = load ? memout : aluout;
  assign taken = (beq & zero) | (bne & ~zero);
  assign pc_next = jr ? rs_val
                 : jump ? {pc4[31:28], inst[25:0], 2'b00}
                 : taken ? pc4 + {imm[29:0], 2'b00}
                 : pc4;
  // rf[0] is cleared on reset and never written, so $0 reads as zero
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      pc <= pc_next;
      if (wreg && dst != 5'd0) rf[dst] <= wdata;
    end
  end
  always_ff @(posedge mem_clk) begin
    if (store) ram[aluout[DW+1:2]] <= rt_val;
  end
endmodule

// File: tb/tb_total_cpu.sv
// tb_total_cpu: two CPUs (default ROM and an ALU/jump-heavy ROM) against an instruction-level model
`timescale 1ns/1ps
module tb_total_cpu;
  localparam logic [2047:0] ROM_B = {
    {(40*32){1'b0}},
    32'h03E00008, 32'h00000000, 32'h00000000, 32'h14A00002,
    32'h1000FFEC, 32'h0000003F, 32'hFC000000, 32'h0C000014,
    32'h16220005, 32'h8E110004, 32'hAE020004, 32'h3C108000,
    32'h304F8001, 32'h384EFFFF, 32'h01226826, 32'h01226025,
    32'h01225824, 32'h00A45022, 32'h00854820, 32'h00024102,
    32'h00021843, 32'h2002FFF8, 32'h00052080, 32'h20050004
  };
  localparam logic [31:0] PROG_A [8] = '{
    32'h3C010000, 32'h34240050, 32'h20050004, 32'hAC850000,
    32'h8C860000, 32'h10A60001, 32'h20070001, 32'h08000000
  };
`ifdef TOTAL_CPU_SHIFT_EN
  localparam logic [31:0] SHIFT_EXP = 32'd16;
`else
  localparam logic [31:0] SHIFT_EXP = 32'd0;
`endif
  logic clock, reset, mem_clk;
  logic [31:0] dinst [2];
  logic [31:0] dpc [2];
  logic [31:0] dalu [2];
  logic [31:0] dmem [2];
  int checks = 0, errors = 0;
  logic [31:0] rom [2][64];
  logic [31:0] mreg [2][32];
  logic [31:0] mram [2][32];
  logic [31:0] mpc [2];
  bit mval [2][32];

  total_cpu u_a (.clock(clock), .reset(reset), .mem_clk(mem_clk),
    .inst(dinst[0]), .pc(dpc[0]), .aluout(dalu[0]), .memout(dmem[0]));
  total_cpu #(.ROM(ROM_B)) u_b (.clock(clock), .reset(reset), .mem_clk(mem_clk),
    .inst(dinst[1]), .pc(dpc[1]), .aluout(dalu[1]), .memout(dmem[1]));

  initial begin
    clock = 0;
    #10;
    forever begin clock = 1; #5; clock = 0; #5; end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  // One instruction interpreted straight from the ISA rules
  function automatic void mdl(input int k, output logic [31:0] alu, output logic [31:0] npc,
                              output logic [31:0] sd, output logic wr, output logic st,
                              output logic ld, output logic [4:0] dst);
    logic [31:0] w, s, t, se, ze, p4;
    w = rom[k][mpc[k][7:2]];
    s = mreg[k][w[25:21]];
    t = mreg[k][w[20:16]];
    se = {{16{w[15]}}, w[15:0]};
    ze = {16'h0, w[15:0]};
    p4 = mpc[k] + 32'd4;
    alu = 0; npc = p4; sd = t; wr = 0; st = 0; ld = 0; dst = w[20:16];
    case (w[31:26])
      6'h00: begin
        dst = w[15:11];
        wr = 1;
        case (w[5:0])
          6'h20: alu = s + t;
          6'h22: alu = s - t;
          6'h24: alu = s & t;
          6'h25: alu = s | t;
          6'h26: alu = s ^ t;
`ifdef TOTAL_CPU_SHIFT_EN
          6'h00: alu = t << w[10:6];
          6'h02: alu = t >> w[10:6];
          6'h03: alu = $signed(t) >>> w[10:6];
`endif
          6'h08: begin wr = 0; npc = s; end
          default: wr = 0;
        endcase
      end
      6'h02: npc = {p4[31:28], w[25:0], 2'b00};
      6'h03: begin npc = {p4[31:28], w[25:0], 2'b00}; alu = p4; wr = 1; dst = 5'd31; end
      6'h04: begin alu = s - t; if (alu == 0) npc = p4 + (se << 2); end
      6'h05: begin alu = s - t; if (alu != 0) npc = p4 + (se << 2); end
      6'h08: begin alu = s + se; wr = 1; end
      6'h0c: begin alu = s & ze; wr = 1; end
      6'h0d: begin alu = s | ze; wr = 1; end
      6'h0e: begin alu = s ^ ze; wr = 1; end
      6'h0f: begin alu = {w[15:0], 16'h0}; wr = 1; end
      6'h23: begin alu = s + se; wr = 1; ld = 1; end
      6'h2b: begin alu = s + se; st = 1; end
      default: ;
    endcase
  endfunction

  task automatic mrst();
    for (int k = 0; k < 2; k++) begin
      mpc[k] = 0;
      for (int i = 0; i < 32; i++) mreg[k][i] = 0;
    end
  endtask

  task automatic compare();
    logic [31:0] a, np, sd;
    logic wr, st, ld;
    logic [4:0] d;
    for (int k = 0; k < 2; k++) begin
      mdl(k, a, np, sd, wr, st, ld, d);
      chk($sformatf("pc%0d", k), dpc[k], mpc[k]);
      chk($sformatf("inst%0d", k), dinst[k], rom[k][mpc[k][7:2]]);
      chk($sformatf("aluout%0d", k), dalu[k], a);
      if (mval[k][a[6:2]]) chk($sformatf("memout%0d", k), dmem[k], mram[k][a[6:2]]);
    end
  endtask

  task automatic hit_rst();
    reset = 0;
    #1;
    mrst();
    chk("async_pc0", dpc[0], 32'h0);
    chk("async_pc1", dpc[1], 32'h0);
  endtask

  // Entered at posedge+1; returns at the next posedge+1
  task automatic cycle(input bit pulse, input int rst_at);
    logic [31:0] a [2];
    logic [31:0] np [2];
    logic [31:0] sd [2];
    logic wr [2];
    logic st [2];
    logic ld [2];
    logic [4:0] d [2];
    compare();
    if (rst_at == 1) hit_rst();
    #1;
    if (pulse) begin
      for (int k = 0; k < 2; k++) begin
        mdl(k, a[k], np[k], sd[k], wr[k], st[k], ld[k], d[k]);
        if (st[k]) begin
          mram[k][a[k][6:2]] = sd[k];
          mval[k][a[k][6:2]] = 1;
        end
      end
      mem_clk = 1;
      #1 mem_clk = 0;
    end else #1;
    if (rst_at == 2) hit_rst();
    for (int k = 0; k < 2; k++) mdl(k, a[k], np[k], sd[k], wr[k], st[k], ld[k], d[k]);
    @(posedge clock);
    #1;
    if (reset) for (int k = 0; k < 2; k++) begin
      if (wr[k] && d[k] != 0) mreg[k][d[k]] = ld[k] ? mram[k][a[k][6:2]] : a[k];
      mpc[k] = np[k];
    end
  endtask

  initial begin
    logic [2047:0] rb;
    int n, hold;
    reset = 1;
    mem_clk = 0;
    rb = ROM_B;
    for (int i = 0; i < 64; i++) begin
      rom[0][i] = i < 8 ? PROG_A[i] : 32'h0;
      rom[1][i] = rb[i*32 +: 32];
    end
    for (int k = 0; k < 2; k++) for (int i = 0; i < 32; i++) mval[k][i] = 0;
    #1 reset = 0;
    mrst();
    #6;
    chk("rst_pc", dpc[0], 32'h0);
    chk("rst_inst", dinst[0], 32'h3C010000);
    chk("rst_alu", dalu[0], 32'h0);
    #4;
    chk("rst_hold_pc", dpc[0], 32'h0);
    reset = 1;
    cycle(1, 0);
    chk("ori_pc", dpc[0], 32'h4);
    chk("ori_alu", dalu[0], 32'h50);
    chk("sll_alu", dalu[1], SHIFT_EXP);
    cycle(1, 0);
    chk("addi_pc", dpc[0], 32'h8);
    chk("addi_inst", dinst[0], 32'h20050004);
    chk("addi_alu", dalu[0], 32'h4);
    cycle(1, 0);
    cycle(1, 0);
    chk("lw_pc", dpc[0], 32'h10);
    chk("lw_alu", dalu[0], 32'h50);
    chk("lw_mem", dmem[0], 32'h4);
    cycle(1, 0);
    chk("beq_pc", dpc[0], 32'h14);
    chk("beq_alu", dalu[0], 32'h0);
    cycle(1, 0);
    chk("beq_target", dpc[0], 32'h1C);
    cycle(1, 0);
    chk("j_target", dpc[0], 32'h0);
    repeat (4) cycle(1, 0);
    chk("pre_rst_pc", dpc[0], 32'h10);
    cycle(1, 1);
    reset = 1;
    repeat (4) cycle(0, 0);
    chk("keep_pc", dpc[0], 32'h10);
    chk("ram_keep", dmem[0], 32'h4);
    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(3, 45);
      repeat (n) cycle(1, 0);
      cycle(1, $urandom_range(1, 2));
      hold = $urandom_range(0, 2);
      repeat (hold) cycle(1, 0);
      reset = 1;
    end
    repeat (30) cycle(1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
